vlane_element_sequencer: RTL
============================

// Module: vlane_element_sequencer
// PURPOSE
//  Walks the element index space of an issued RV32V arithmetic op, NUM_LANES elements per beat,
//  producing per-lane element indices, byte offsets, activity masks and vreg selects for the lanes.
//  Sits between vector decode/issue and the lane register-read stage. It generalises the fixed
//  VLEN=128 / 4-lane constants into parameters, and adds vstart resume, prestart/tail masking,
//  backpressure, kill and an illegal-config error.
// PARAMETERS
//  VLEN       128  vector register width in bits (power of 2, >=64)
//  NUM_LANES  4    elements issued per beat (power of 2)
//  ELEN       32   largest supported SEW in bits; SEW>ELEN is illegal
//  derived: VLENB=VLEN/8; VL_W=$clog2(VLEN)+1; BO_W=$clog2(VLENB)
//  elaboration check: VLENB/(ELEN/8) >= NUM_LANES, so one beat never spans two registers
// PORTS
//  CLK          in   1               clock
//  RST          in   1               synchronous, active-high reset
//  start_valid  in   1               issue request
//  start_ready  out  1               sequencer idle, can accept
//  vl           in   VL_W            vector length
//  vstart       in   VL_W            first element to execute
//  vsew         in   3               vsew_t
//  vlmul        in   3               vlmul_t
//  vd_base      in   5               destination register group base
//  vs1_base     in   5               source 1 register group base
//  vs2_base     in   5               source 2 register group base
//  kill         in   1               flush current op
//  out_valid    out  1               beat valid
//  out_ready    in   1               lanes accept beat
//  lane_active  out  NUM_LANES       bit l = lane l element is in [vstart, vl)
//  elem_idx     out  NUM_LANES*VL_W  lane l index at [l*VL_W +: VL_W]
//  byte_off     out  NUM_LANES*BO_W  lane l byte offset within register
//  vd_sel       out  5               vd_base + register offset
//  vs1_sel      out  5               vs1_base + register offset
//  vs2_sel      out  5               vs2_base + register offset
//  last         out  1               final beat of op
//  done         out  1               1-cycle pulse, op complete
//  err          out  1               1-cycle pulse, illegal config
// BEHAVIOUR
//  Reset: state IDLE; out_valid, lane_active, elem_idx, byte_off, *_sel, last, done, err = 0.
//  FSM IDLE/RUN. start_ready = (state==IDLE). Accept = start_valid & start_ready.
//  On accept, latch all inputs and compute VLMAX = (VLEN>>(3+vsew)), then <<lmul (LMUL1..8) or
//  >>n (fractional).
//  - vsew>log2(ELEN/8), vlmul==3'd4, or vl>VLMAX: err=1 next cycle; stay IDLE; no beats.
//  - else if vstart>=vl: done=1 next cycle; stay IDLE; no beats.
//  - else: idx = vstart & ~(NUM_LANES-1); go RUN; out_valid=1 next cycle (1-cycle latency).
//  Beat payload for lane l, with e=idx+l and EPR=VLENB>>vsew:
//  - elem_idx=e; lane_active = (e>=vstart)&&(e<vl).
//  - byte_off=(e%EPR)<<vsew; reg offset = e/EPR; *_sel = base + offset, mod 32.
//  - last = (idx+NUM_LANES >= vl).
//  Payload is registered and held stable while out_valid & !out_ready.
//  On out_valid & out_ready: if last, go IDLE, out_valid=0 and done=1 next cycle; else idx+=NUM_LANES.
//  kill (priority below RST): next cycle IDLE, out_valid=0, no done/err; a start in the same cycle
//  is ignored.
//  RST mid-op is identical to kill, plus all outputs return to reset values.
//  done/err never assert together; no new start is accepted while RUN.
// STRUCTURE
//  rv32v_types_pkg gains vseq_state_t {VSEQ_IDLE, VSEQ_RUN} and
//  function vlmax(vsew_t, vlmul_t, int vlen).
//  One sub-module, vseq_lane_addr (combinational), maps idx/vsew/bases to the per-lane payload.
//  The FSM and idx counter stay in the top module.
// TESTING (VLEN=128, NUM_LANES=4, ELEN=32)
//  1. vl=10, SEW32, LMUL4, vstart=0, vd_base=8, out_ready=1 -> 3 beats.
//     vd_sel 8,9,10; lane_active 1111,1111,0011; last on beat 3; done next cycle.
//  2. vl=16, SEW8, LMUL1, vstart=6 -> beats at idx 4,8,12.
//     Beat 0: lane_active 1100, byte_off 4..7. last at idx 12.
//  3. Case 1 with out_ready=0 for 3 cycles on beat 2 -> payload stable, no skipped or duplicated beats.
//  4. vstart=vl=5 -> no out_valid, done=1 one cycle after accept.
//     vl=33, SEW32, LMUL8 -> err=1, no beats.
//  5. kill during beat 2 of case 1 -> out_valid=0 next cycle, no done.
//     A new start is accepted the following cycle and runs correctly.
//  6. RST asserted mid-run with start_valid=1 -> all outputs 0 next cycle, start_ready=1 after release.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared RV32V encodings plus the sequencer state type and the VLMAX helper.
package rv32v_types_pkg;

   typedef enum logic [2:0] {
      SEW8  = 3'd0,
      SEW16 = 3'd1,
      SEW32 = 3'd2,
      SEW64 = 3'd3
   } vsew_t;

   typedef enum logic [2:0] {
      LMUL1    = 3'd0,
      LMUL2    = 3'd1,
      LMUL4    = 3'd2,
      LMUL8    = 3'd3,
      LMUL_RSV = 3'd4,
      LMULF8   = 3'd5,
      LMULF4   = 3'd6,
      LMULF2   = 3'd7
   } vlmul_t;

   typedef enum logic {
      VSEQ_IDLE = 1'b0,
      VSEQ_RUN  = 1'b1
   } vseq_state_t;

   // Elements per register group: VLEN/SEW scaled by LMUL (fractional codes 5..7 divide by 8..2).
   function automatic int vlmax(vsew_t sew, vlmul_t lmul, int vlen);
      logic [2:0] m;
      int         base;
      m    = lmul;
      base = vlen >> (3 + int'(sew));
      if (!m[2]) return base << m[1:0];
      else       return base >> (8 - int'(m));
   endfunction

endpackage

// File: rtl/vseq_lane_addr.sv
// Combinational map from a beat's base element index to the per-lane payload.
module vseq_lane_addr
   import rv32v_types_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int VL_W      = 8,
   parameter int BO_W      = 4
)(
   input  logic [VL_W-1:0]           i_idx,
   input  logic [VL_W-1:0]           i_vl,
   input  logic [VL_W-1:0]           i_vstart,
   input  logic [2:0]                i_vsew,
   input  logic [4:0]                i_vd_base,
   input  logic [4:0]                i_vs1_base,
   input  logic [4:0]                i_vs2_base,
   output logic [NUM_LANES-1:0]      o_lane_active,
   output logic [NUM_LANES*VL_W-1:0] o_elem_idx,
   output logic [NUM_LANES*BO_W-1:0] o_byte_off,
   output logic [4:0]                o_vd_sel,
   output logic [4:0]                o_vs1_sel,
   output logic [4:0]                o_vs2_sel,
   output logic                      o_last
);

   // Wide enough for idx+lane and a <<vsew byte address without wrapping.
   localparam int EW = VL_W + 4;

   logic [EW-1:0] w_base_byte;
   logic [4:0]    w_roff;

   // A beat never straddles registers, so lane 0's byte address picks the register.
   // byte_off = (e % EPR) << vsew is the low BO_W bits of e << vsew; the rest is the reg offset.
   assign w_base_byte = EW'(i_idx) << i_vsew;
   assign w_roff      = 5'(w_base_byte >> BO_W);
   assign o_vd_sel    = i_vd_base  + w_roff;
   assign o_vs1_sel   = i_vs1_base + w_roff;
   assign o_vs2_sel   = i_vs2_base + w_roff;
   assign o_last      = (EW'(i_idx) + EW'(NUM_LANES)) >= EW'(i_vl);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [EW-1:0] w_e;
      logic [EW-1:0] w_eb;
      assign w_e  = EW'(i_idx) + EW'(l);
      assign w_eb = w_e << i_vsew;
      assign o_elem_idx[l*VL_W +: VL_W] = VL_W'(w_e);
      assign o_byte_off[l*BO_W +: BO_W] = BO_W'(w_eb);
      assign o_lane_active[l] = (w_e >= EW'(i_vstart)) && (w_e < EW'(i_vl));
   end

endmodule

// File: rtl/vlane_element_sequencer.sv
// Walks [vstart, vl) of an issued vector op NUM_LANES elements per beat, with
// backpressure, kill and config checking. Payload is registered (1-cycle latency).
module vlane_element_sequencer
   import rv32v_types_pkg::*;
#(
   parameter  int VLEN      = 128,
   parameter  int NUM_LANES = 4,
   parameter  int ELEN      = 32,
   localparam int VLENB     = VLEN / 8,
   localparam int VL_W      = $clog2(VLEN) + 1,
   localparam int BO_W      = $clog2(VLENB)
)(
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic [VL_W-1:0]           vl,
   input  logic [VL_W-1:0]           vstart,
   input  logic [2:0]                vsew,
   input  logic [2:0]                vlmul,
   input  logic [4:0]                vd_base,
   input  logic [4:0]                vs1_base,
   input  logic [4:0]                vs2_base,
   input  logic                      kill,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_LANES-1:0]      lane_active,
   output logic [NUM_LANES*VL_W-1:0] elem_idx,
   output logic [NUM_LANES*BO_W-1:0] byte_off,
   output logic [4:0]                vd_sel,
   output logic [4:0]                vs1_sel,
   output logic [4:0]                vs2_sel,
   output logic                      last,
   output logic                      done,
   output logic                      err
);

   localparam int SEW_MAX = $clog2(ELEN / 8);

   if (VLENB / (ELEN / 8) < NUM_LANES) begin : g_bad_cfg
      $error("vlane_element_sequencer: one beat would span two registers");
   end

   vseq_state_t r_state, w_nstate;

   logic [VL_W-1:0] r_idx, r_vl, r_vstart;
   logic [2:0]      r_vsew;
   logic [4:0]      r_vd, r_vs1, r_vs2;
   logic            r_out_valid, r_last, r_done, r_err;
   logic [NUM_LANES-1:0]      r_act;
   logic [NUM_LANES*VL_W-1:0] r_eidx;
   logic [NUM_LANES*BO_W-1:0] r_boff;
   logic [4:0]                r_vd_sel, r_vs1_sel, r_vs2_sel;

   logic            w_accept, w_cfg_bad, w_empty, w_go, w_fire, w_adv, w_end;
   logic [31:0]     w_vlmax;
   logic [VL_W-1:0] w_s_idx, w_s_vl, w_s_vstart;
   logic [2:0]      w_s_vsew;
   logic [4:0]      w_s_vd, w_s_vs1, w_s_vs2;
   logic [NUM_LANES-1:0]      w_act;
   logic [NUM_LANES*VL_W-1:0] w_eidx;
   logic [NUM_LANES*BO_W-1:0] w_boff;
   logic [4:0]                w_vd_sel, w_vs1_sel, w_vs2_sel;
   logic                      w_last;

   // kill wins over a same-cycle start, so the start is simply not taken.
   assign w_accept  = start_valid && (r_state == VSEQ_IDLE) && !kill;
   assign w_vlmax   = 32'(vlmax(vsew_t'(vsew), vlmul_t'(vlmul), VLEN));
   assign w_cfg_bad = (vsew > 3'(SEW_MAX)) || (vlmul == 3'd4) || (32'(vl) > w_vlmax);
   assign w_empty   = (vstart >= vl);
   assign w_go      = w_accept && !w_cfg_bad && !w_empty;
   assign w_fire    = r_out_valid && out_ready;
   assign w_adv     = w_fire && !r_last;
   assign w_end     = w_fire && r_last;

   // The address mapper computes the next beat: first beat from the inputs, later ones from latched config.
   assign w_s_idx    = w_go ? (vstart & ~VL_W'(NUM_LANES - 1)) : (r_idx + VL_W'(NUM_LANES));
   assign w_s_vl     = w_go ? vl       : r_vl;
   assign w_s_vstart = w_go ? vstart   : r_vstart;
   assign w_s_vsew   = w_go ? vsew     : r_vsew;
   assign w_s_vd     = w_go ? vd_base  : r_vd;
   assign w_s_vs1    = w_go ? vs1_base : r_vs1;
   assign w_s_vs2    = w_go ? vs2_base : r_vs2;

   vseq_lane_addr #(
      .NUM_LANES (NUM_LANES),
      .VL_W      (VL_W),
      .BO_W      (BO_W)
   ) u_addr (
      .i_idx         (w_s_idx),
      .i_vl          (w_s_vl),
      .i_vstart      (w_s_vstart),
      .i_vsew        (w_s_vsew),
      .i_vd_base     (w_s_vd),
      .i_vs1_base    (w_s_vs1),
      .i_vs2_base    (w_s_vs2),
      .o_lane_active (w_act),
      .o_elem_idx    (w_eidx),
      .o_byte_off    (w_boff),
      .o_vd_sel      (w_vd_sel),
      .o_vs1_sel     (w_vs1_sel),
      .o_vs2_sel     (w_vs2_sel),
      .o_last        (w_last)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) r_state <= VSEQ_IDLE;
      else     r_state <= w_nstate;
   end

   // Next state: IDLE->RUN on a legal non-empty start; RUN->IDLE on kill or final handshake.
   always_comb begin
      w_nstate = r_state;
      case (r_state)
         VSEQ_IDLE: if (w_go) w_nstate = VSEQ_RUN;
         VSEQ_RUN:  if (kill || w_end) w_nstate = VSEQ_IDLE;
         default:   w_nstate = VSEQ_IDLE;
      endcase
   end

   // Outputs: handshake from state, everything else straight from the payload registers.
   always_comb begin
      start_ready = (r_state == VSEQ_IDLE);
      out_valid   = r_out_valid;
      lane_active = r_act;
      elem_idx    = r_eidx;
      byte_off    = r_boff;
      vd_sel      = r_vd_sel;
      vs1_sel     = r_vs1_sel;
      vs2_sel     = r_vs2_sel;
      last        = r_last;
      done        = r_done;
      err         = r_err;
   end

   // Latch op config on a real start; the mapper reads it for later beats.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_vl <= '0; r_vstart <= '0; r_vsew <= '0;
         r_vd <= '0; r_vs1 <= '0; r_vs2 <= '0;
      end else if (w_go) begin
         r_vl <= vl; r_vstart <= vstart; r_vsew <= vsew;
         r_vd <= vd_base; r_vs1 <= vs1_base; r_vs2 <= vs2_base;
      end
   end

   // Beat counter, payload registers and done/err pulses; payload holds while stalled.
   always_ff @(posedge CLK) begin
      if (RST || kill) begin
         r_out_valid <= 1'b0; r_last <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
         r_act <= '0; r_eidx <= '0; r_boff <= '0;
         r_vd_sel <= '0; r_vs1_sel <= '0; r_vs2_sel <= '0;
         if (RST) r_idx <= '0;
      end else begin
         r_done <= w_accept && !w_cfg_bad && w_empty;
         r_err  <= w_accept && w_cfg_bad;
         if (w_go || w_adv) begin
            r_idx       <= w_s_idx;
            r_out_valid <= 1'b1;
            r_act       <= w_act;
            r_eidx      <= w_eidx;
            r_boff      <= w_boff;
            r_vd_sel    <= w_vd_sel;
            r_vs1_sel   <= w_vs1_sel;
            r_vs2_sel   <= w_vs2_sel;
            r_last      <= w_last;
         end else if (w_end) begin
            r_out_valid <= 1'b0; r_last <= 1'b0; r_done <= 1'b1;
            r_act <= '0; r_eidx <= '0; r_boff <= '0;
            r_vd_sel <= '0; r_vs1_sel <= '0; r_vs2_sel <= '0;
         end
      end
   end

endmodule
